vram_dma_m: RTL and testbench
=============================

// Module: vram_dma_m
// PURPOSE
//  CPU-side initiator of the VRAM write interface (address/data/write_enable) consumed by the background and sprite renderers.
//  Copies LEN bytes from main memory (req/ack read port) into VRAM starting at DST, through a small FIFO.
//  VRAM writes are issued only while vblank is high, so active-video scanout never sees torn tiles.
//  Sits between the CPU bus decoder (start/abort/config) and the GPU VRAM write port.
// PARAMETERS
//  FIFO_DEPTH  4   byte buffer entries; power of two, >=2
//  SRC_W       16  main-memory address width
//  ADDR_W      12  VRAM address width; equals `VRAM_ADDR_WIDTH
//  LEN_W       12  transfer length width; max length 2**LEN_W-1
// PORTS
//  cpu_clk           in   1       sole clock; all state changes on posedge, qualified by cpu_clk_enable
//  rst               in   1       asynchronous, active-low reset
//  cpu_clk_enable    in   1       advance qualifier; when low, all state and outputs hold
//  start             in   1       launch the transfer; sampled in IDLE only
//  abort             in   1       cancel the transfer; priority over everything except rst
//  src_addr          in   SRC_W   first main-memory byte; latched on start
//  dst_addr          in   ADDR_W  first VRAM byte; latched on start
//  length            in   LEN_W   byte count; latched on start
//  vblank            in   1       high = VRAM writes permitted
//  mem_req           out  1       read request; held until mem_ack
//  mem_addr          out  SRC_W   read address; stable while mem_req is high
//  mem_ack           in   1       read complete; mem_rdata is valid this cycle
//  mem_rdata         in   8       read byte
//  vram_address      out  ADDR_W  VRAM write address
//  vram_data         out  8       VRAM write data
//  vram_write_enable out  1       one enabled cycle per byte; renderer samples it on the following negedge
//  busy              out  1       high in RUN and FLUSH
//  done              out  1       one enabled-cycle pulse on normal completion
// BEHAVIOUR
//  Reset: state=IDLE; FIFO empty; all outputs 0.
//  States: IDLE -> RUN (start, length!=0) | DONE (start, length==0); RUN -> FLUSH when the last read is acked;
//   FLUSH -> DONE when the FIFO is empty and the last write has issued; DONE -> IDLE after 1 cycle (done=1 there).
//  start while busy is ignored; the latched config is unaffected.
//  Reads: at most one outstanding. mem_req rises only if (FIFO count < FIFO_DEPTH) and reads remain.
//   mem_req/mem_addr are held until mem_ack. On an ack cycle: push mem_rdata, mem_addr++ (wraps mod 2**SRC_W),
//   reads_left--. A new request may assert on the cycle after an ack.
//  Writes: in any cycle where vblank && FIFO !empty, pop the head and register vram_data=head, vram_address=dst_ptr,
//   vram_write_enable=1; dst_ptr++ wraps mod 2**ADDR_W. Otherwise vram_write_enable=0.
//   Latency from ack to write is 1 cycle if vblank is high and the FIFO was empty.
//  Push and pop may occur in the same cycle, including at full (pop frees the slot); count is unchanged.
//  vblank falling mid-transfer stalls writes only; reads continue until the FIFO is full.
//  abort (any state): next enabled cycle -> IDLE, FIFO flushed, mem_req=0, write_enable=0, no done pulse.
//   A mem_ack arriving the cycle after abort is ignored.
//  rst asserted mid-transfer: immediate reset values; the requester must tolerate the dropped mem_req.
//  Byte order is preserved exactly; total writes == latched length.
// STRUCTURE
//  Package gpu_dma_pkg: typedef enum logic[1:0] {IDLE,RUN,FLUSH,DONE} dma_state_t; VRAM_PMB_BASE=12'h200,
//   VRAM_NTBL_BASE=12'h400 (shared with the renderers).
//  Sub-module byte_fifo_m (FIFO_DEPTH): push/pop/full/empty/count, async active-low reset, enable qualifier.
//  Top: FSM, read sequencer, write port register.
// TESTING
//  1 src=0x8000 dst=0x200 len=16, vblank=1, ack 1 cycle after req -> 16 writes to 0x200..0x20F with the memory bytes; one done pulse.
//  2 len=8, vblank=0 throughout -> exactly FIFO_DEPTH(4) acks, then mem_req stays low; 0 writes; vblank=1 -> all 8 written in order.
//  3 dst=0xFFE len=4 -> writes to 0xFFE,0xFFF,0x000,0x001; src=0xFFFF wraps mem_addr to 0x0000.
//  4 start with len=0 -> no mem_req, no write, done on the 2nd enabled cycle; start while busy -> ignored.
//  5 abort after 3 writes of len=10 -> IDLE, no further writes, no done; a late mem_ack is ignored; rst low mid-run -> all outputs 0.
//  6 cpu_clk_enable toggled 1-in-4 -> identical write sequence to test 1; outputs held on disabled cycles.

Source files
------------

// File: rtl/gpu_dma_pkg.sv
// Shared types and VRAM map constants for the CPU-side VRAM DMA engine.
package gpu_dma_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} dma_state_t;

    localparam logic [11:0] VRAM_PMB_BASE  = 12'h200;
    localparam logic [11:0] VRAM_NTBL_BASE = 12'h400;

endpackage

// File: rtl/byte_fifo_m.sv
// Small byte FIFO between the main-memory reader and the VRAM write port.
module byte_fifo_m #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    // A pop in the same cycle frees the slot, so a push at full is accepted then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (en) begin
            if (flush) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (do_push) wr_q <= wr_q + AW'(1);
                if (do_pop)  rd_q <= rd_q + AW'(1);
                cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en && !flush && do_push) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/vram_dma_m.sv
// Main-memory to VRAM byte copier; writes only during vblank, one read outstanding.
module vram_dma_m
    import gpu_dma_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SRC_W      = 16,
    parameter int ADDR_W     = 12,
    parameter int LEN_W      = 12
) (
    input  logic              cpu_clk,
    input  logic              rst,
    input  logic              cpu_clk_enable,
    input  logic              start,
    input  logic              abort,
    input  logic [SRC_W-1:0]  src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              vblank,
    output logic              mem_req,
    output logic [SRC_W-1:0]  mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [ADDR_W-1:0] vram_address,
    output logic [7:0]        vram_data,
    output logic              vram_write_enable,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    dma_state_t        state_q, state_d;
    logic [SRC_W-1:0]  mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] dst_q, dst_d, vaddr_q, vaddr_d;
    logic [LEN_W-1:0]  reads_q, reads_d, reads_nxt;
    logic [7:0]        vdata_q, vdata_d;
    logic              req_q, req_d, vwe_q, vwe_d;

    logic          push, pop, active, ack_v, room_nxt;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;

    byte_fifo_m #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (cpu_clk),
        .rst_n (rst),
        .en    (cpu_clk_enable),
        .flush (abort),
        .push  (push),
        .din   (mem_rdata),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign active    = (state_q == RUN) || (state_q == FLUSH);
    assign ack_v     = (state_q == RUN) && req_q && mem_ack && !abort;
    assign push      = ack_v;
    assign pop       = active && vblank && !fifo_empty && !abort;
    assign reads_nxt = reads_q - LEN_W'(ack_v);
    // Free slot after this cycle's push/pop; gates the next request.
    assign room_nxt  = !((fifo_full && !pop) ||
                         (push && !pop && fifo_count == CW'(FIFO_DEPTH - 1)));

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        dst_d      = dst_q;
        reads_d    = reads_q;
        req_d      = req_q;
        vaddr_d    = vaddr_q;
        vdata_d    = vdata_q;
        vwe_d      = 1'b0;
        if (abort) begin
            state_d = IDLE;
            req_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    mem_addr_d = src_addr;
                    dst_d      = dst_addr;
                    reads_d    = length;
                    req_d      = (length != '0);
                    state_d    = (length != '0) ? RUN : DONE;
                end
                RUN: begin
                    if (ack_v) begin
                        mem_addr_d = mem_addr_q + SRC_W'(1);
                        reads_d    = reads_nxt;
                        if (reads_nxt == '0) state_d = FLUSH;
                    end
                    req_d = (req_q && !mem_ack) || (reads_nxt != '0 && room_nxt);
                end
                FLUSH: begin
                    req_d = 1'b0;
                    if (fifo_empty) state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
            if (pop) begin
                vdata_d = fifo_head;
                vaddr_d = dst_q;
                vwe_d   = 1'b1;
                dst_d   = dst_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            dst_q      <= '0;
            reads_q    <= '0;
            req_q      <= 1'b0;
            vaddr_q    <= '0;
            vdata_q    <= '0;
            vwe_q      <= 1'b0;
        end else if (cpu_clk_enable) begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            dst_q      <= dst_d;
            reads_q    <= reads_d;
            req_q      <= req_d;
            vaddr_q    <= vaddr_d;
            vdata_q    <= vdata_d;
            vwe_q      <= vwe_d;
        end
    end

    assign mem_req           = req_q;
    assign mem_addr          = mem_addr_q;
    assign vram_address      = vaddr_q;
    assign vram_data         = vdata_q;
    assign vram_write_enable = vwe_q;
    assign busy              = active;
    assign done              = (state_q == DONE);

endmodule

// File: tb/tb_vram_dma_m.sv
// Directed bench for vram_dma_m with a write scoreboard and a simple memory responder.
module tb_vram_dma_m;

    logic        cpu_clk = 1'b0, rst = 1'b0, cpu_clk_enable = 1'b1;
    logic        start = 1'b0, abort = 1'b0, vblank = 1'b0, mem_ack = 1'b0;
    logic [15:0] src_addr = '0;
    logic [11:0] dst_addr = '0, length = '0;
    logic [7:0]  mem_rdata = '0;
    logic        mem_req, vram_write_enable, busy, done;
    logic [15:0] mem_addr;
    logic [11:0] vram_address;
    logic [7:0]  vram_data;

    int n_cmp = 0, n_err = 0, wr_cnt = 0, done_cnt = 0, ack_cnt = 0, ph = 0;
    int force_req = 0, force_seen = 0;
    bit en_mode = 1'b0, old_en;
    logic [19:0] sb[$];
    logic [19:0] exp_w;
    logic [39:0] outs, snap = '0;

    vram_dma_m dut (
        .cpu_clk(cpu_clk), .rst(rst), .cpu_clk_enable(cpu_clk_enable),
        .start(start), .abort(abort), .src_addr(src_addr), .dst_addr(dst_addr),
        .length(length), .vblank(vblank), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .vram_address(vram_address),
        .vram_data(vram_data), .vram_write_enable(vram_write_enable),
        .busy(busy), .done(done)
    );

    always #5 cpu_clk = ~cpu_clk;

    assign outs = {mem_req, mem_addr, vram_address, vram_data, vram_write_enable, busy, done};

    function automatic logic [7:0] membyte(input logic [15:0] a);
        return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'hA5;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory responder, clock-enable pattern and write/done monitor, all on the falling edge.
    always @(negedge cpu_clk) begin
        old_en = cpu_clk_enable;
        if (en_mode && !old_en) chk("hold", outs, snap);
        if (force_req != force_seen) begin
            force_seen = force_req;
            mem_ack    = 1'b1;
            mem_rdata  = 8'hEE;
        end else if (mem_ack && (old_en || !mem_req)) begin
            mem_ack = 1'b0;
        end else if (!mem_ack && mem_req) begin
            mem_ack   = 1'b1;
            mem_rdata = membyte(mem_addr);
            ack_cnt++;
        end
        cpu_clk_enable = en_mode ? (ph == 0) : 1'b1;
        ph = (ph + 1) % 4;
        if (vram_write_enable && cpu_clk_enable) begin
            exp_w = (sb.size() != 0) ? sb.pop_front() : 'x;
            wr_cnt++;
            chk("write", {vram_address, vram_data}, exp_w);
        end
        if (done && cpu_clk_enable) done_cnt++;
        snap = outs;
    end

    task automatic step(input int n);
        repeat (n) @(posedge cpu_clk);
        #1;
    endtask

    task automatic edge_en();
        do @(posedge cpu_clk); while (!cpu_clk_enable);
        #1;
    endtask

    task automatic do_start(input logic [15:0] s, input logic [11:0] d, input logic [11:0] n,
                            input bit expect_it);
        src_addr = s;
        dst_addr = d;
        length   = n;
        if (expect_it)
            for (int i = 0; i < int'(n); i++) sb.push_back({12'(d + i), membyte(16'(s + i))});
        start = 1'b1;
        edge_en();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0 = done_cnt;
        int k  = 0;
        while (done_cnt == d0 && k < budget) begin
            step(1);
            k++;
        end
        chk({tag, "_done_seen"}, done_cnt > d0, 1);
        step(8);
        chk({tag, "_one_done"}, done_cnt - d0, 1);
    endtask

    initial begin
        int w0, w1, a0, d0, k;
        step(3);
        chk("rst_req", mem_req, 0);
        chk("rst_we", vram_write_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_all", outs, 0);
        rst = 1'b1;
        step(1);

        // 1: plain 16-byte copy in vblank
        vblank = 1'b1;
        w0 = wr_cnt; a0 = ack_cnt;
        do_start(16'h8000, 12'h200, 16, 1);
        chk("t1_busy", busy, 1);
        wait_done("t1", 300);
        chk("t1_writes", wr_cnt - w0, 16);
        chk("t1_acks", ack_cnt - a0, 16);
        chk("t1_sb", sb.size(), 0);

        // 2: no vblank -> reads stop at FIFO depth
        vblank = 1'b0;
        w0 = wr_cnt; a0 = ack_cnt;
        do_start(16'h1234, 12'h300, 8, 1);
        step(40);
        chk("t2_acks", ack_cnt - a0, 4);
        chk("t2_req_low", mem_req, 0);
        chk("t2_no_wr", wr_cnt - w0, 0);
        chk("t2_busy", busy, 1);
        vblank = 1'b1;
        wait_done("t2", 300);
        chk("t2_writes", wr_cnt - w0, 8);
        chk("t2_sb", sb.size(), 0);

        // 3: address wrap on both sides
        w0 = wr_cnt;
        do_start(16'hFFFF, 12'hFFE, 4, 1);
        wait_done("t3", 300);
        chk("t3_mem_addr", mem_addr, 16'h0003);
        chk("t3_writes", wr_cnt - w0, 4);
        chk("t3_sb", sb.size(), 0);

        // 4: zero length, then start while busy
        w0 = wr_cnt; d0 = done_cnt;
        do_start(16'h0000, 12'h000, 0, 1);
        chk("t4_done", done, 1);
        chk("t4_req", mem_req, 0);
        chk("t4_busy", busy, 0);
        step(1);
        chk("t4_done_end", done, 0);
        chk("t4_pulses", done_cnt - d0, 1);
        chk("t4_no_wr", wr_cnt - w0, 0);
        vblank = 1'b0;
        do_start(16'h4000, 12'h400, 8, 1);
        step(3);
        do_start(16'h0100, 12'h050, 2, 0);
        chk("t4_still_busy", busy, 1);
        vblank = 1'b1;
        wait_done("t4b", 300);
        chk("t4_writes", wr_cnt - w0, 8);
        chk("t4_sb", sb.size(), 0);

        // 5: abort mid-transfer, late ack, then reset mid-transfer
        w0 = wr_cnt; d0 = done_cnt;
        do_start(16'h2000, 12'h500, 10, 1);
        k = 0;
        while (wr_cnt - w0 < 3 && k < 100) begin
            step(1);
            k++;
        end
        chk("t5_three_wr", wr_cnt - w0 >= 3, 1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        sb.delete();
        w1 = wr_cnt;
        force_req++;
        chk("t5_busy", busy, 0);
        chk("t5_req", mem_req, 0);
        chk("t5_we", vram_write_enable, 0);
        step(20);
        chk("t5_no_wr", wr_cnt - w1, 0);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_idle", busy, 0);
        do_start(16'h3000, 12'h600, 12, 1);
        step(6);
        rst = 1'b0;
        #1;
        chk("t5_rst_outs", outs, 0);
        step(1);
        sb.delete();
        rst = 1'b1;
        step(2);

        // 6: 1-in-4 clock enable, same copy as test 1
        en_mode = 1'b1;
        w0 = wr_cnt;
        do_start(16'h8000, 12'h200, 16, 1);
        wait_done("t6", 2000);
        chk("t6_writes", wr_cnt - w0, 16);
        chk("t6_sb", sb.size(), 0);
        en_mode = 1'b0;
        step(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
